data_mem_ctrl: RTL and testbench
================================

Name: data_mem_ctrl

Overview:
- Parametrised, byte-addressed, big-endian data memory for the core's load/store unit.
- Successor to the single-cycle combinational data memory: requests and responses use valid/ready handshakes.
- Each access is serialised one byte per cycle, so the storage has a single byte port.
- Adds configurable depth, an optional alignment check, bounds and illegal-op error reporting, and a registered response.

Parameters:
- ADDR_BITS, 8, byte-address width.
- DEPTH, 256, number of bytes stored. Must satisfy DEPTH <= 2^ADDR_BITS and DEPTH >= 4.
- ALIGN_CHECK, 1, when 1, a halfword at an odd address or a word at an address not divisible by 4 is an error; when 0, unaligned accesses are allowed.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_op  in  4  operation code: 0000 NOP, 0001 SW, 0010 SH, 0011 SB, 0100 LW, 0101 LH, 0110 LB, 0111 LHU, 1000 LBU; 1001-1111 illegal.
- req_addr  in  ADDR_BITS  byte address of the most significant byte.
- req_wdata  in  32  store data; SH uses [15:0], SB uses [7:0].
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_rdata  out  32  load result after extension; 0 for stores, NOP and errors.
- rsp_err  out  1  request was rejected; memory is unchanged.
- busy  out  1  high in XFER and RESP.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; req_ready=1; rsp_valid=0; rsp_rdata=0; rsp_err=0; busy=0; byte counter=0.
  - Every memory byte cleared to 0x00, except byte 3, which is 0x04 (preserves the existing boot value).
  - Reset in the middle of an access aborts it. Bytes already written stay cleared by the reset; no response is produced.
- State IDLE:
  - req_ready=1.
  - On req_valid&&req_ready, latch op, addr and wdata. Set N = 4 for LW/SW, 2 for SH/LH/LHU, 1 for SB/LB/LBU.
  - Error check, all conditions ORed: illegal op; addr+N-1 >= DEPTH (evaluated in ADDR_BITS+1 bits, no wrap-around); misaligned when ALIGN_CHECK=1.
  - If error or NOP: go to RESP on the next edge, with rsp_err=error and rsp_rdata=0.
  - Otherwise: counter=0, go to XFER.
- State XFER:
  - req_ready=0.
  - Each cycle handles byte addr+counter.
  - Stores write wdata byte N-1-counter. The MSB goes to the lowest address (big-endian).
  - Loads shift the byte into an accumulator, MSB first.
  - When counter==N-1, go to RESP; otherwise counter increments.
  - Exactly N XFER cycles per access.
- State RESP:
  - rsp_valid=1. rsp_rdata and rsp_err are held stable until the handshake.
  - Extension: LW raw; LH sign-extends bit 15; LHU zero-extends; LB sign-extends bit 7; LBU zero-extends.
  - On rsp_ready go to IDLE; rsp_valid drops on that edge.
  - req_ready stays 0, so there is no overlap: the next request is accepted the cycle after returning to IDLE.
- Latency, from the acceptance edge to the first cycle with rsp_valid=1:
  - N+1 cycles for a valid access.
  - 1 cycle for NOP or error.
  - Back-to-back LW with rsp_ready held at 1: one request per 6 cycles.
- Req inputs are ignored outside IDLE.
- rsp_ready is ignored outside RESP.
- Memory is written only in XFER.
- Reads in XFER see data from earlier, completed stores only.

Test Plan:
- Reset release, then LW addr 0 with rsp_ready=1 -> rsp_valid high 5 cycles after accept; rsp_rdata=0x00000004; rsp_err=0.
- SW 0xDEADBEEF @0x10, then LB @0x10, LBU @0x10, LH @0x12, LHU @0x12, LW @0x10 -> 0xFFFFFFDE, 0x000000DE, 0xFFFFBEEF, 0x0000BEEF, 0xDEADBEEF; byte 0x11 = 0xAD.
- SB 0x7F @0x21, then SH 0x8001 @0x22, then LW @0x20 -> 0x007F8001. SH response asserts 3 cycles after accept.
- ALIGN_CHECK=1: LW @0x02 -> rsp_err=1 one cycle after accept, rsp_rdata=0. Illegal op 1010 -> rsp_err=1. DEPTH=64: SW @0x3E with ALIGN_CHECK=0 -> rsp_err=1 and bytes 0x3E/0x3F unchanged.
- Hold rsp_ready=0 for 7 cycles in RESP after LH -> rsp_valid and rsp_rdata stable, req_ready=0, a new req_valid is ignored. Release -> IDLE on the next edge and the new request is accepted the cycle after.
- Assert rst=0 during the 2nd XFER cycle of SW 0x11223344 @0x08 -> outputs return to reset values immediately; a later LW @0x08 returns 0x00000000; no stale response appears.

Source files
------------

// File: rtl/data_mem_ctrl_if.sv
// Request/response handshake bundle between the load/store unit and the data memory.
// Master drives requests and rsp_ready; slave returns req_ready and the registered response.
interface data_mem_ctrl_if #(
   parameter int ADDR_BITS = 8
);
   logic                 req_valid;
   logic                 req_ready;
   logic [3:0]           req_op;
   logic [ADDR_BITS-1:0] req_addr;
   logic [31:0]          req_wdata;
   logic                 rsp_valid;
   logic                 rsp_ready;
   logic [31:0]          rsp_rdata;
   logic                 rsp_err;

   modport master (
      output req_valid, req_op, req_addr, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_op, req_addr, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/data_mem_ctrl.sv
// Big-endian byte-serial data memory: N+1 cycles per access (1 for NOP/error), one access in flight.
// req_ready only in IDLE; the response is held until rsp_ready.
module data_mem_ctrl #(
   parameter int ADDR_BITS   = 8,
   parameter int DEPTH       = 256,
   parameter int ALIGN_CHECK = 1
) (
   input  logic            clk,
   input  logic            rst,
   data_mem_ctrl_if.slave  bus,
   output logic            busy
);
   typedef enum logic [1:0] {IDLE, XFER, RESP} state_t;

   state_t               state_q, state_d;
   logic [3:0]           op_q;
   logic [ADDR_BITS-1:0] addr_q;
   logic [31:0]          wdata_q;
   logic [1:0]           last_q, cnt_q;
   logic [31:0]          acc_q, rdata_q;
   logic                 err_q;
   logic [7:0]           mem [DEPTH];

   // Request decode: last = N-1
   logic                 op_legal, op_nop, out_of_range, misaligned, req_err;
   logic [1:0]           last;
   logic [ADDR_BITS:0]   end_addr;

   always_comb begin
      op_legal = 1'b1;
      op_nop   = 1'b0;
      last     = 2'd0;
      case (bus.req_op)
         4'h0: op_nop = 1'b1;
         4'h1, 4'h4: last = 2'd3;
         4'h2, 4'h5, 4'h7: last = 2'd1;
         4'h3, 4'h6, 4'h8: last = 2'd0;
         default: op_legal = 1'b0;
      endcase
      end_addr     = {1'b0, bus.req_addr} + (ADDR_BITS+1)'(last);
      out_of_range = end_addr >= (ADDR_BITS+1)'(DEPTH);
      misaligned   = (ALIGN_CHECK != 0) &&
                     (((last == 2'd1) && bus.req_addr[0]) ||
                      ((last == 2'd3) && (bus.req_addr[1:0] != 2'b00)));
      req_err      = !op_legal || (!op_nop && (out_of_range || misaligned));
   end

   // Datapath for the byte being transferred this cycle
   logic                 is_load_q;
   logic [ADDR_BITS-1:0] idx;
   logic [1:0]           lane;
   logic [7:0]           rbyte, wbyte;
   logic [31:0]          acc_nx, ext;

   always_comb begin
      is_load_q = op_q[2] | op_q[3];
      idx       = addr_q + ADDR_BITS'(cnt_q);
      rbyte     = mem[idx];
      lane      = last_q - cnt_q;
      case (lane)
         2'd0:    wbyte = wdata_q[7:0];
         2'd1:    wbyte = wdata_q[15:8];
         2'd2:    wbyte = wdata_q[23:16];
         default: wbyte = wdata_q[31:24];
      endcase
      acc_nx = {acc_q[23:0], rbyte};
      case (op_q)
         4'h5:    ext = {{16{acc_nx[15]}}, acc_nx[15:0]};
         4'h7:    ext = {16'h0, acc_nx[15:0]};
         4'h6:    ext = {{24{acc_nx[7]}}, acc_nx[7:0]};
         4'h8:    ext = {24'h0, acc_nx[7:0]};
         default: ext = acc_nx;
      endcase
   end

   always_comb begin
      state_d       = state_q;
      bus.req_ready = (state_q == IDLE);
      bus.rsp_valid = (state_q == RESP);
      bus.rsp_rdata = rdata_q;
      bus.rsp_err   = err_q;
      busy          = (state_q != IDLE);
      case (state_q)
         IDLE: if (bus.req_valid) state_d = (req_err || op_nop) ? RESP : XFER;
         XFER: if (cnt_q == last_q) state_d = RESP;
         RESP: if (bus.rsp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         op_q    <= 4'h0;
         addr_q  <= '0;
         wdata_q <= 32'h0;
         last_q  <= 2'd0;
         cnt_q   <= 2'd0;
         acc_q   <= 32'h0;
         rdata_q <= 32'h0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         case (state_q)
            IDLE: if (bus.req_valid) begin
               op_q    <= bus.req_op;
               addr_q  <= bus.req_addr;
               wdata_q <= bus.req_wdata;
               last_q  <= last;
               cnt_q   <= 2'd0;
               acc_q   <= 32'h0;
               rdata_q <= 32'h0;
               err_q   <= req_err;
            end
            XFER: begin
               acc_q <= acc_nx;
               if (cnt_q == last_q) begin
                  if (is_load_q) rdata_q <= ext;
               end else begin
                  cnt_q <= cnt_q + 2'd1;
               end
            end
            default: ;
         endcase
      end
   end

   // Byte 3 carries the legacy boot value
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= (i == 3) ? 8'h04 : 8'h00;
      end else if (state_q == XFER && !is_load_q) begin
         mem[idx] <= wbyte;
      end
   end
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: a vector table over two configurations plus
// hand sequences for response backpressure and reset during a transfer.
module tb_data_mem_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic busy0, busy1;

   always #5 clk = ~clk;

   data_mem_ctrl_if #(.ADDR_BITS(8)) bus0 ();
   data_mem_ctrl_if #(.ADDR_BITS(8)) bus1 ();

   data_mem_ctrl #(.ADDR_BITS(8), .DEPTH(256), .ALIGN_CHECK(1)) dut0 (
      .clk(clk), .rst(rst), .bus(bus0), .busy(busy0));
   data_mem_ctrl #(.ADDR_BITS(8), .DEPTH(64), .ALIGN_CHECK(0)) dut1 (
      .clk(clk), .rst(rst), .bus(bus1), .busy(busy1));

   typedef struct {
      bit          sel;
      logic [3:0]  op;
      logic [7:0]  addr;
      logic [31:0] wd;
      logic [31:0] rd;
      logic        err;
      int          lat;
   } vec_t;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, want %h", nm, act, exp);
      end
   endtask

   function automatic logic rv(input bit sel);
      return sel ? bus1.rsp_valid : bus0.rsp_valid;
   endfunction

   task automatic wait_rsp(input bit sel, output int lat);
      lat = 1;
      while (!rv(sel) && lat < 30) begin
         @(negedge clk);
         lat++;
      end
      if (!rv(sel)) begin
         n_cmp++;
         n_bad++;
         $display("FAIL rsp_timeout: got no rsp_valid, want rsp_valid within 30 cycles");
      end
   endtask

   task automatic finish_rsp(input bit sel);
      if (sel) bus1.rsp_ready = 1'b1; else bus0.rsp_ready = 1'b1;
      @(negedge clk);
      bus0.rsp_ready = 1'b0;
      bus1.rsp_ready = 1'b0;
   endtask

   task automatic do_req(input bit sel, input logic [3:0] op, input logic [7:0] addr,
                         input logic [31:0] wd, output logic [31:0] rd, output logic er,
                         output int lat);
      @(negedge clk);
      bus0.req_op = op;  bus0.req_addr = addr;  bus0.req_wdata = wd;
      bus1.req_op = op;  bus1.req_addr = addr;  bus1.req_wdata = wd;
      bus0.req_valid = !sel;
      bus1.req_valid = sel;
      @(negedge clk);
      bus0.req_valid = 1'b0;
      bus1.req_valid = 1'b0;
      wait_rsp(sel, lat);
      rd = sel ? bus1.rsp_rdata : bus0.rsp_rdata;
      er = sel ? bus1.rsp_err : bus0.rsp_err;
      finish_rsp(sel);
   endtask

   vec_t        tv [28];
   logic [31:0] rd;
   logic        er;
   int          lat;
   logic        stale;

   initial begin
      tv[0]  = '{0, 4'h4, 8'h00, 32'h0,        32'h00000004, 1'b0, 5};
      tv[1]  = '{0, 4'h1, 8'h10, 32'hDEADBEEF, 32'h0,        1'b0, 5};
      tv[2]  = '{0, 4'h6, 8'h10, 32'h0,        32'hFFFFFFDE, 1'b0, 2};
      tv[3]  = '{0, 4'h8, 8'h10, 32'h0,        32'h000000DE, 1'b0, 2};
      tv[4]  = '{0, 4'h5, 8'h12, 32'h0,        32'hFFFFBEEF, 1'b0, 3};
      tv[5]  = '{0, 4'h7, 8'h12, 32'h0,        32'h0000BEEF, 1'b0, 3};
      tv[6]  = '{0, 4'h4, 8'h10, 32'h0,        32'hDEADBEEF, 1'b0, 5};
      tv[7]  = '{0, 4'h8, 8'h11, 32'h0,        32'h000000AD, 1'b0, 2};
      tv[8]  = '{0, 4'h3, 8'h21, 32'hAAAAAA7F, 32'h0,        1'b0, 2};
      tv[9]  = '{0, 4'h2, 8'h22, 32'h55558001, 32'h0,        1'b0, 3};
      tv[10] = '{0, 4'h4, 8'h20, 32'h0,        32'h007F8001, 1'b0, 5};
      tv[11] = '{0, 4'h4, 8'h02, 32'h0,        32'h0,        1'b1, 1};
      tv[12] = '{0, 4'hA, 8'h00, 32'h0,        32'h0,        1'b1, 1};
      tv[13] = '{0, 4'h0, 8'h00, 32'hFFFFFFFF, 32'h0,        1'b0, 1};
      tv[14] = '{0, 4'h5, 8'h13, 32'h0,        32'h0,        1'b1, 1};
      tv[15] = '{0, 4'h1, 8'h11, 32'h12345678, 32'h0,        1'b1, 1};
      tv[16] = '{0, 4'h8, 8'h11, 32'h0,        32'h000000AD, 1'b0, 2};
      tv[17] = '{0, 4'h6, 8'hFF, 32'h0,        32'h0,        1'b0, 2};
      tv[18] = '{0, 4'hF, 8'h40, 32'h0,        32'h0,        1'b1, 1};
      tv[19] = '{1, 4'h2, 8'h3E, 32'h00001234, 32'h0,        1'b0, 3};
      tv[20] = '{1, 4'h1, 8'h3E, 32'hAABBCCDD, 32'h0,        1'b1, 1};
      tv[21] = '{1, 4'h7, 8'h3E, 32'h0,        32'h00001234, 1'b0, 3};
      tv[22] = '{1, 4'h4, 8'h3D, 32'h0,        32'h0,        1'b1, 1};
      tv[23] = '{1, 4'h4, 8'h3C, 32'h0,        32'h00001234, 1'b0, 5};
      tv[24] = '{1, 4'h4, 8'h01, 32'h0,        32'h00000400, 1'b0, 5};
      tv[25] = '{1, 4'h6, 8'h40, 32'h0,        32'h0,        1'b1, 1};
      tv[26] = '{1, 4'h8, 8'h3F, 32'h0,        32'h00000034, 1'b0, 2};
      tv[27] = '{1, 4'h5, 8'h3F, 32'h0,        32'h0,        1'b1, 1};

      bus0.req_valid = 1'b0; bus0.req_op = 4'h0; bus0.req_addr = 8'h0;
      bus0.req_wdata = 32'h0; bus0.rsp_ready = 1'b0;
      bus1.req_valid = 1'b0; bus1.req_op = 4'h0; bus1.req_addr = 8'h0;
      bus1.req_wdata = 32'h0; bus1.rsp_ready = 1'b0;

      #3 rst = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_req_ready", {31'h0, bus0.req_ready}, 32'h1);
      chk("rst_rsp_valid", {31'h0, bus0.rsp_valid}, 32'h0);
      chk("rst_rsp_rdata", bus0.rsp_rdata, 32'h0);
      chk("rst_rsp_err",   {31'h0, bus0.rsp_err}, 32'h0);
      chk("rst_busy",      {31'h0, busy0}, 32'h0);
      rst = 1'b1;

      for (int i = 0; i < 28; i++) begin
         do_req(tv[i].sel, tv[i].op, tv[i].addr, tv[i].wd, rd, er, lat);
         chk($sformatf("v%0d_rdata", i), rd, tv[i].rd);
         chk($sformatf("v%0d_err", i), {31'h0, er}, {31'h0, tv[i].err});
         chk($sformatf("v%0d_lat", i), lat, tv[i].lat);
      end

      // Response backpressure: LH held for 7 cycles while a new request waits
      @(negedge clk);
      bus0.req_op = 4'h5; bus0.req_addr = 8'h12; bus0.req_valid = 1'b1;
      @(negedge clk);
      bus0.req_valid = 1'b0;
      wait_rsp(1'b0, lat);
      chk("hold_lat", lat, 3);
      bus0.req_op = 4'h3; bus0.req_addr = 8'h10; bus0.req_wdata = 32'h00000099;
      bus0.req_valid = 1'b1;
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         chk("hold_rsp_valid", {31'h0, bus0.rsp_valid}, 32'h1);
         chk("hold_rsp_rdata", bus0.rsp_rdata, 32'hFFFFBEEF);
         chk("hold_req_ready", {31'h0, bus0.req_ready}, 32'h0);
         chk("hold_busy",      {31'h0, busy0}, 32'h1);
      end
      bus0.rsp_ready = 1'b1;
      @(negedge clk);
      bus0.rsp_ready = 1'b0;
      chk("rel_rsp_valid", {31'h0, bus0.rsp_valid}, 32'h0);
      chk("rel_req_ready", {31'h0, bus0.req_ready}, 32'h1);
      @(negedge clk);
      bus0.req_valid = 1'b0;
      chk("rel_accept_busy", {31'h0, busy0}, 32'h1);
      wait_rsp(1'b0, lat);
      chk("rel_sb_err", {31'h0, bus0.rsp_err}, 32'h0);
      finish_rsp(1'b0);
      do_req(1'b0, 4'h8, 8'h10, 32'h0, rd, er, lat);
      chk("rel_sb_byte10", rd, 32'h00000099);
      do_req(1'b0, 4'h8, 8'h11, 32'h0, rd, er, lat);
      chk("rel_byte11", rd, 32'h000000AD);

      // Reset during the second XFER cycle of a store
      @(negedge clk);
      bus0.req_op = 4'h1; bus0.req_addr = 8'h08; bus0.req_wdata = 32'h11223344;
      bus0.req_valid = 1'b1;
      @(negedge clk);
      bus0.req_valid = 1'b0;
      chk("mid_busy", {31'h0, busy0}, 32'h1);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("mid_rst_busy",      {31'h0, busy0}, 32'h0);
      chk("mid_rst_req_ready", {31'h0, bus0.req_ready}, 32'h1);
      chk("mid_rst_rsp_valid", {31'h0, bus0.rsp_valid}, 32'h0);
      chk("mid_rst_rsp_err",   {31'h0, bus0.rsp_err}, 32'h0);
      chk("mid_rst_rsp_rdata", bus0.rsp_rdata, 32'h0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      stale = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (bus0.rsp_valid) stale = 1'b1;
      end
      chk("no_stale_rsp", {31'h0, stale}, 32'h0);
      do_req(1'b0, 4'h4, 8'h08, 32'h0, rd, er, lat);
      chk("post_rst_lw08", rd, 32'h00000000);
      do_req(1'b0, 4'h4, 8'h10, 32'h0, rd, er, lat);
      chk("post_rst_lw10", rd, 32'h00000000);
      do_req(1'b0, 4'h4, 8'h00, 32'h0, rd, er, lat);
      chk("post_rst_lw00", rd, 32'h00000004);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
